// File: rtl/pc_seq_unit_pkg.sv
// pc_seq_unit_pkg: shared constants and types for the PC sequencer.
//   Instruction field offsets, the sequential PC step, and the next-PC
//   source enumeration used by pc_seq_unit.
package pc_seq_unit_pkg;

  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned JIDX_MSB = 25;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    NPC_RESET,
    NPC_HOLD,
    NPC_RET,
    NPC_JUMP,
    NPC_BRANCH,
    NPC_SEQ
  } npc_src_e;

endpackage

// File: rtl/pc_seq_unit_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, rst          : clock, synchronous active-high reset
//   push              : write wdata above the top (overwrites oldest when full)
//   pop               : drop the top entry (no-op when empty)
//   replace           : overwrite the top entry; acts as push when empty
//   wdata [PC_W]      : return address to store
//   top   [PC_W]      : current top entry (don't-care when empty)
//   empty, full       : registered occupancy flags
module ras_stack
  import pc_seq_unit_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [PC_W-1:0] wdata,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic             r_empty;
  logic             r_full;

  logic             w_is_empty;
  logic             w_do_push;
  logic             w_do_repl;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_is_empty = (r_cnt == '0);
  assign w_do_push  = push | (replace & w_is_empty);
  assign w_do_repl  = replace & ~w_is_empty;
  assign w_do_pop   = pop & ~w_is_empty;

  // r_ptr addresses the top entry; a full push advances it onto the oldest
  // slot, so the ring overwrites in age order without a separate tail.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    if (w_do_push) begin
      w_ptr_nxt = r_ptr + PTR_W'(1);
      if (r_cnt != CNT_W'(RAS_DEPTH)) w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (w_do_pop) begin
      w_ptr_nxt = r_ptr - PTR_W'(1);
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == CNT_W'(RAS_DEPTH));
      if (w_do_push)      r_mem[w_ptr_nxt] <= wdata;
      else if (w_do_repl) r_mem[r_ptr]     <= wdata;
    end
  end

  assign top   = r_mem[r_ptr];
  assign empty = r_empty;
  assign full  = r_full;

endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with immediate decode.
//   CLK, reset        : clock, synchronous active-high reset
//   Instr [32]        : current instruction (MIPS-style fields)
//   Jump, Bzero       : J-type jump, taken branch
//   Call              : with Jump, a jal (pushes return address)
//   Ret, Rdata [PC_W] : return, register-file return target
//   Stall             : hold PC and RAS
//   imm [32]          : sign-extended Instr[15:0] (combinational)
//   PC [PC_W]         : registered current PC
//   PC_plus4 [PC_W]   : PC+4 (combinational)
//   ras_empty/ras_full: registered RAS flags (RAS_EN only)
// Build option: define RAS_EN to include the return-address stack.
module pc_seq_unit
  import pc_seq_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [31:0]     Instr,
  input  logic            Jump,
  input  logic            Bzero,
  input  logic            Call,
  input  logic            Ret,
  input  logic            Stall,
  input  logic [PC_W-1:0] Rdata,
  output logic [31:0]     imm,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_plus4
`ifdef RAS_EN
  ,
  output logic            ras_empty,
  output logic            ras_full
`endif
);

  logic [PC_W-1:0] r_pc;
  logic [31:0]     w_pc32;
  logic [31:0]     w_pc4_32;
  logic [31:0]     w_bt32;
  logic [31:0]     w_jt32;
  logic [PC_W-1:0] w_ret;
  logic [PC_W-1:0] w_npc;
  npc_src_e        w_src;

  assign imm      = {{16{Instr[IMM_MSB]}}, Instr[IMM_MSB:IMM_LSB]};
  assign w_pc32   = 32'(r_pc);
  assign w_pc4_32 = w_pc32 + PC_STEP;
  assign w_bt32   = w_pc4_32 + (imm << 2);
  assign w_jt32   = {w_pc4_32[31:28], Instr[JIDX_MSB:0], 2'b00};
  assign PC       = r_pc;
  assign PC_plus4 = w_pc4_32[PC_W-1:0];

`ifdef RAS_EN
  logic            w_jal;
  logic            w_push;
  logic            w_pop;
  logic            w_repl;
  logic [PC_W-1:0] w_ras_top;
  logic            w_unused;

  assign w_jal  = Jump & Call;
  assign w_push = w_jal & ~Stall & ~Ret;
  assign w_pop  = Ret & ~Stall & ~w_jal;
  assign w_repl = Ret & w_jal & ~Stall;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk     (CLK),
    .rst     (reset),
    .push    (w_push),
    .pop     (w_pop),
    .replace (w_repl),
    .wdata   (PC_plus4),
    .top     (w_ras_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );

  assign w_ret    = ras_empty ? Rdata : w_ras_top;
  assign w_unused = ^Instr[31:26];
`else
  logic w_unused;

  // Without the stack, Call and RAS_DEPTH have no function.
  assign w_ret    = Rdata;
  assign w_unused = ^{Instr[31:26], Call, 32'(RAS_DEPTH)};
`endif

  always_comb begin
    w_src = NPC_SEQ;
    if (reset)      w_src = NPC_RESET;
    else if (Stall) w_src = NPC_HOLD;
    else if (Ret)   w_src = NPC_RET;
    else if (Jump)  w_src = NPC_JUMP;
    else if (Bzero) w_src = NPC_BRANCH;
  end

  always_comb begin
    w_npc = w_pc4_32[PC_W-1:0];
    unique case (w_src)
      NPC_RESET:  w_npc = RESET_PC[PC_W-1:0];
      NPC_HOLD:   w_npc = r_pc;
      NPC_RET:    w_npc = w_ret;
      NPC_JUMP:   w_npc = w_jt32[PC_W-1:0];
      NPC_BRANCH: w_npc = w_bt32[PC_W-1:0];
      default:    w_npc = w_pc4_32[PC_W-1:0];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) r_pc <= RESET_PC[PC_W-1:0];
    else       r_pc <= w_npc;
  end

endmodule
